// File: rtl/tbre_sweep_sched.sv
// tbre_sweep_sched: request queue and launch scheduler for the background
// revocation engine. Requesters are arbitrated round-robin into a small FIFO.
// The FSM launches the head entry on the engine's start/end/go interface,
// follows the engine's busy flag, and reports one done pulse per entry.
// Successful sweeps advance a 32-bit completion epoch.
//
// Build option TBRE_SCHED_RANGE_CHECK_EN: when defined, a head entry with
// end <= start is never launched. It completes immediately with an error.
//
// state      | meaning
// -----------+----------------------------------------------------------
// IDLE       | no sweep in flight; start/end latched when a head exists
// LAUNCH     | go pulse to the engine, timeout counter cleared
// WAIT_START | waiting for the engine to raise busy (timeout applies)
// RUN        | engine busy; waiting for busy to fall (timeout applies)
// DONE       | done pulse, head popped, epoch bumped on success
// RECOVER    | timed-out sweep still running; hold off until busy falls
module tbre_sweep_sched #(
  parameter int NREQ      = 2,
  parameter int QDEPTH    = 4,
  parameter int TIMEOUT_W = 16,
  localparam int ID_W     = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int PTR_W    = $clog2(QDEPTH),
  localparam int CNT_W    = PTR_W + 1
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic [NREQ-1:0]      req_valid_i,
  input  logic [NREQ*32-1:0]   req_start_i,
  input  logic [NREQ*32-1:0]   req_end_i,
  output logic [NREQ-1:0]      req_ready_o,
  input  logic [TIMEOUT_W-1:0] timeout_i,
  output logic [31:0]          tbre_start_o,
  output logic [31:0]          tbre_end_o,
  output logic                 tbre_go_o,
  input  logic                 tbre_busy_i,
  output logic                 done_valid_o,
  output logic [ID_W-1:0]      done_id_o,
  output logic                 done_err_o,
  output logic [31:0]          epoch_o,
  output logic [CNT_W-1:0]     q_count_o,
  output logic                 sched_busy_o
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LAUNCH     = 3'd1,
    S_WAIT_START = 3'd2,
    S_RUN        = 3'd3,
    S_DONE       = 3'd4,
    S_RECOVER    = 3'd5
  } state_t;

  state_t state_q, state_d;

  logic [ID_W-1:0]      rr_q, rr_d;
  logic [ID_W-1:0]      gnt_idx;
  logic                 gnt_found;
  logic [31:0]          gnt_start, gnt_end;
  logic                 space_ok;
  logic                 push;
  logic                 pop;

  logic [PTR_W-1:0]     head_q, tail_q;
  logic [CNT_W-1:0]     count_q;
  logic [ID_W-1:0]      mem_id_q    [QDEPTH];
  logic [31:0]          mem_start_q [QDEPTH];
  logic [31:0]          mem_end_q   [QDEPTH];

  logic [31:0]          start_q, start_d;
  logic [31:0]          end_q, end_d;
  logic [31:0]          epoch_q, epoch_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic                 to_hit;
  logic                 err_q, err_d;
  logic                 head_bad;

  // Round-robin pick: first valid requester at or above the pointer, else the lowest valid one.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    gnt_start = '0;
    gnt_end   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!gnt_found && req_valid_i[i] && (ID_W'(i) >= rr_q)) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_W'(i);
        gnt_start = req_start_i[32*i +: 32];
        gnt_end   = req_end_i[32*i +: 32];
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!gnt_found && req_valid_i[i]) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_W'(i);
        gnt_start = req_start_i[32*i +: 32];
        gnt_end   = req_end_i[32*i +: 32];
      end
    end
  end

  // Space is judged on the pre-pop count, so a full queue never accepts in its pop cycle.
  assign space_ok = (count_q < CNT_W'(QDEPTH));
  assign push     = space_ok && gnt_found;

  // One-hot accept towards the winning requester.
  always_comb begin
    req_ready_o = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready_o[i] = push && (gnt_idx == ID_W'(i));
    end
  end

  // Priority moves to the requester after the one just granted.
  always_comb begin
    rr_d = rr_q;
    if (push) begin
      rr_d = (gnt_idx == ID_W'(NREQ - 1)) ? '0 : gnt_idx + ID_W'(1);
    end
  end

  // Queue storage; contents only matter while counted, so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_id_q[tail_q]    <= gnt_idx;
      mem_start_q[tail_q] <= gnt_start;
      mem_end_q[tail_q]   <= gnt_end;
    end
  end

  // Queue pointers, occupancy and arbitration pointer.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      rr_q    <= '0;
    end else begin
      rr_q <= rr_d;
      if (push) tail_q <= tail_q + PTR_W'(1);
      if (pop)  head_q <= head_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // The counter saturates, and the compare looks at the value including this cycle.
  // A timeout of N therefore fires N cycles after go.
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + TIMEOUT_W'(1);
  assign to_hit  = (timeout_i != '0) && (cnt_inc == timeout_i);

`ifdef TBRE_SCHED_RANGE_CHECK_EN
  assign head_bad = (mem_end_q[head_q] <= mem_start_q[head_q]);
`else
  assign head_bad = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic, engine handshake outputs and datapath next values.
  always_comb begin
    state_d      = state_q;
    start_d      = start_q;
    end_d        = end_q;
    epoch_d      = epoch_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    pop          = 1'b0;
    tbre_go_o    = 1'b0;
    done_valid_o = 1'b0;
    done_id_o    = '0;
    done_err_o   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          if (head_bad) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            start_d = mem_start_q[head_q];
            end_d   = mem_end_q[head_q];
            state_d = S_LAUNCH;
          end
        end
      end
      S_LAUNCH: begin
        tbre_go_o = 1'b1;
        cnt_d     = '0;
        state_d   = S_WAIT_START;
      end
      S_WAIT_START: begin
        cnt_d = cnt_inc;
        // A zero-length sweep may never raise busy, so the timeout wins a tie here.
        if (to_hit) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (tbre_busy_i) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        cnt_d = cnt_inc;
        // An engine that finishes in the timeout cycle is reported as a success.
        if (!tbre_busy_i) begin
          err_d   = 1'b0;
          state_d = S_DONE;
        end else if (to_hit) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_valid_o = 1'b1;
        done_id_o    = mem_id_q[head_q];
        done_err_o   = err_q;
        pop          = 1'b1;
        if (!err_q) epoch_d = epoch_q + 32'd1;
        state_d = (err_q && tbre_busy_i) ? S_RECOVER : S_IDLE;
        err_d   = 1'b0;
      end
      S_RECOVER: begin
        if (!tbre_busy_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Launch address, epoch, timeout counter and completion status.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      start_q <= '0;
      end_q   <= '0;
      epoch_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      start_q <= start_d;
      end_q   <= end_d;
      epoch_q <= epoch_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign tbre_start_o = start_q;
  assign tbre_end_o   = end_q;
  assign epoch_o      = epoch_q;
  assign q_count_o    = count_q;
  assign sched_busy_o = (state_q != S_IDLE);

endmodule

// File: tb/tb_tbre_sweep_sched.sv
// Testbench for tbre_sweep_sched. The bench plays the requesters and the
// engine. Each sweep's go, done, error and return-to-idle cycles are worked
// out arithmetically from the engine's busy window and the timeout when the
// sweep is launched.
module tb_tbre_sweep_sched;
  localparam int NREQ   = 2;
  localparam int QDEPTH = 4;
  localparam int TW     = 16;

  logic              clk_i = 1'b0;
  logic              rstn_i;
  logic [NREQ-1:0]   req_valid_i;
  logic [NREQ*32-1:0] req_start_i;
  logic [NREQ*32-1:0] req_end_i;
  logic [NREQ-1:0]   req_ready_o;
  logic [TW-1:0]     timeout_i;
  logic [31:0]       tbre_start_o;
  logic [31:0]       tbre_end_o;
  logic              tbre_go_o;
  logic              tbre_busy_i;
  logic              done_valid_o;
  logic [0:0]        done_id_o;
  logic              done_err_o;
  logic [31:0]       epoch_o;
  logic [2:0]        q_count_o;
  logic              sched_busy_o;

  always #5 clk_i = ~clk_i;

  tbre_sweep_sched #(.NREQ(NREQ), .QDEPTH(QDEPTH), .TIMEOUT_W(TW)) dut (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .req_valid_i  (req_valid_i),
    .req_start_i  (req_start_i),
    .req_end_i    (req_end_i),
    .req_ready_o  (req_ready_o),
    .timeout_i    (timeout_i),
    .tbre_start_o (tbre_start_o),
    .tbre_end_o   (tbre_end_o),
    .tbre_go_o    (tbre_go_o),
    .tbre_busy_i  (tbre_busy_i),
    .done_valid_o (done_valid_o),
    .done_id_o    (done_id_o),
    .done_err_o   (done_err_o),
    .epoch_o      (epoch_o),
    .q_count_o    (q_count_o),
    .sched_busy_o (sched_busy_o)
  );

  typedef struct packed {
    logic [31:0] s;
    logic [31:0] e;
    logic [7:0]  id;
  } ent_t;

  ent_t        mq[$];
  int          cyc;
  int          rr_m;
  int          idle_at, sb_from, go_at, done_at;
  bit          done_err_m;
  logic [31:0] m_start, m_end, m_epoch;
  int          win_lo, win_hi;
  int          cur_t;
  bit          rnd_eng;
  int          cfg_a, cfg_len, cfg_t;
  logic [31:0] drv_s[NREQ];
  logic [31:0] drv_e[NREQ];
  int          n_vec, n_mis;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    rr_m       = 0;
    idle_at    = 0;
    sb_from    = 0;
    go_at      = -1;
    done_at    = -1;
    done_err_m = 1'b0;
    m_start    = '0;
    m_end      = '0;
    m_epoch    = '0;
    win_lo     = 1;
    win_hi     = 0;
    cur_t      = 0;
  endtask

  task automatic rand_addr(input bit allow_bad);
    for (int i = 0; i < NREQ; i++) begin
      drv_s[i] = 32'($urandom_range(32'h0001_0000, 32'h7fff_0000));
      if (allow_bad && $urandom_range(0, 5) == 0)
        drv_e[i] = drv_s[i] - 32'($urandom_range(0, 15));
      else
        drv_e[i] = drv_s[i] + 32'($urandom_range(1, 4095));
    end
  endtask

  // Decide the whole life of the head entry, which leaves IDLE in cycle t.
  task automatic launch(input int t);
    ent_t ent;
    int   a, len, tt, g, fall;
    bit   rej;
    ent = mq[0];
    if (rnd_eng) begin
      a   = $urandom_range(1, 3);
      tt  = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(4, 20);
      len = ($urandom_range(0, 9) == 0) ? $urandom_range(20, 30) : $urandom_range(0, 12);
      if (tt == 0 && len == 0) len = 1;
    end else begin
      a   = cfg_a;
      len = cfg_len;
      tt  = cfg_t;
    end
    sb_from = t + 1;
    rej = 1'b0;
`ifdef TBRE_SCHED_RANGE_CHECK_EN
    rej = (ent.e <= ent.s);
`endif
    if (rej) begin
      go_at      = -1;
      done_at    = t + 1;
      done_err_m = 1'b1;
      idle_at    = t + 2;
    end else begin
      g       = t + 1;
      go_at   = g;
      m_start = ent.s;
      m_end   = ent.e;
      cur_t   = tt;
      win_lo  = g + a;
      win_hi  = g + a + len - 1;
      fall    = g + a + len;
      if (tt != 0 && (len == 0 || tt < a + len)) begin
        done_err_m = 1'b1;
        done_at    = g + tt + 1;
        idle_at    = (len > 0 && fall > done_at) ? fall + 1 : done_at + 1;
      end else begin
        done_err_m = 1'b0;
        done_at    = fall + 1;
        idle_at    = done_at + 1;
      end
    end
  endtask

  task automatic step(input logic [NREQ-1:0] v);
    logic [NREQ-1:0] ve;
    logic [NREQ-1:0] exp_rdy;
    int   w;
    bit   acc;
    @(negedge clk_i);
    if (!rstn_i) model_reset();
    ve = rstn_i ? v : '0;
    req_valid_i = ve;
    for (int i = 0; i < NREQ; i++) begin
      req_start_i[32*i +: 32] = drv_s[i];
      req_end_i[32*i +: 32]   = drv_e[i];
    end
    tbre_busy_i = (cyc >= win_lo) && (cyc <= win_hi);
    timeout_i   = TW'(cur_t);
    #1;
    w = -1;
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (rr_m + k) % NREQ;
      if (w < 0 && ve[i]) w = i;
    end
    acc = (w >= 0) && (mq.size() < QDEPTH);
    exp_rdy = acc ? NREQ'(1 << w) : '0;
    chk("ready", 32'(req_ready_o), 32'(exp_rdy));
    chk("go", 32'(tbre_go_o), 32'(cyc == go_at));
    chk("start", tbre_start_o, m_start);
    chk("end", tbre_end_o, m_end);
    chk("done_valid", 32'(done_valid_o), 32'(cyc == done_at));
    if (cyc == done_at) begin
      chk("done_id", 32'(done_id_o), 32'(mq[0].id));
      chk("done_err", 32'(done_err_o), 32'(done_err_m));
    end
    chk("q_count", 32'(q_count_o), 32'(mq.size()));
    chk("epoch", epoch_o, m_epoch);
    chk("sched_busy", 32'(sched_busy_o), 32'(cyc >= sb_from && cyc < idle_at));
    if (rstn_i) begin
      if (cyc >= idle_at && mq.size() > 0) launch(cyc);
      if (cyc == done_at) begin
        if (!done_err_m) m_epoch = m_epoch + 32'd1;
        void'(mq.pop_front());
      end
      if (acc) begin
        mq.push_back('{s: drv_s[w], e: drv_e[w], id: 8'(w)});
        rr_m = (w + 1) % NREQ;
      end
    end
    cyc++;
  endtask

  initial begin
    n_vec       = 0;
    n_mis       = 0;
    cyc         = 0;
    rstn_i      = 1'b0;
    req_valid_i = '0;
    req_start_i = '0;
    req_end_i   = '0;
    tbre_busy_i = 1'b0;
    timeout_i   = '0;
    rnd_eng     = 1'b0;
    cfg_a       = 1;
    cfg_len     = 1;
    cfg_t       = 0;
    for (int i = 0; i < NREQ; i++) begin
      drv_s[i] = '0;
      drv_e[i] = '0;
    end
    model_reset();
    repeat (3) step('0);
    rstn_i = 1'b1;

    // Single request, engine busy for 10 cycles right after go.
    cfg_a = 1; cfg_len = 10; cfg_t = 0;
    drv_s[0] = 32'h0000_1000;
    drv_e[0] = 32'h0000_2000;
    step(2'b01);
    repeat (20) step('0);

    // Both requesters always valid: alternating grants until the queue fills.
    cfg_a = 1; cfg_len = 2; cfg_t = 0;
    for (int n = 0; n < 12; n++) begin
      rand_addr(1'b0);
      step(2'b11);
    end
    repeat (60) step('0);

    // Timeout of 8 with the engine stuck busy, then a normal sweep queued behind it.
    cfg_a = 1; cfg_len = 30; cfg_t = 8;
    rand_addr(1'b0);
    step(2'b01);
    step('0);
    cfg_a = 2; cfg_len = 3; cfg_t = 0;
    rand_addr(1'b0);
    step(2'b10);
    repeat (60) step('0);

    // Random traffic with random engine behaviour and a reset in the middle.
    rnd_eng = 1'b1;
    for (int n = 0; n < 2400; n++) begin
      if (n == 1200) begin
        rstn_i = 1'b0;
        step('0);
        step('0);
        rstn_i = 1'b1;
      end
      rand_addr(1'b1);
      if (n % 400 < 200)
        step(NREQ'($urandom));
      else
        step(($urandom_range(0, 7) == 0) ? NREQ'($urandom) : '0);
    end
    repeat (120) step('0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
